// File: rtl/perceptron_pkg.sv
// Shared types for the perceptron classifier: FSM states, accumulator sizing, class labels.
// Pure definitions; no latency or flow control.
package perceptron_pkg;

   typedef enum logic [1:0] {IDLE, ACCUM, DECIDE, HOLD} state_t;

   localparam int CIRCLE = 0;
   localparam int CROSS  = 1;

   // Enough headroom for every pixel hitting the most negative weight.
   function automatic int acc_width(input int w_bits, input int width);
      return w_bits + $clog2(width + 1);
   endfunction

endpackage

// File: rtl/perceptron_mac_lane.sv
// One class lane: weight register file plus signed accumulator, one pixel MAC per enabled cycle.
// Writes land in one cycle; clr has priority over en; no backpressure of its own.
module perceptron_mac_lane #(
   parameter int WIDTH  = 25,
   parameter int W_BITS = 3,
   parameter int ACC_W  = 8,
   parameter int IDX_W  = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en_i,
   input  logic [IDX_W-1:0]         wr_idx_i,
   input  logic signed [W_BITS-1:0] wr_data_i,
   input  logic                     clr_i,
   input  logic                     en_i,
   input  logic [IDX_W-1:0]         pix_idx_i,
   input  logic                     pix_i,
   output logic signed [ACC_W-1:0]  acc_o
);

   logic signed [W_BITS-1:0] w_q [WIDTH];
   logic signed [W_BITS-1:0] w_sel;
   logic signed [ACC_W-1:0]  term;
   logic signed [ACC_W-1:0]  acc_q;
   logic signed [ACC_W-1:0]  acc_d;

   always_comb begin
      w_sel = w_q[pix_idx_i];
      term  = pix_i ? {{(ACC_W-W_BITS){w_sel[W_BITS-1]}}, w_sel} : '0;
      acc_d = acc_q + term;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < WIDTH; i++) w_q[i] <= '0;
         acc_q <= '0;
      end else begin
         if (wr_en_i && (32'(wr_idx_i) < WIDTH)) w_q[wr_idx_i] <= wr_data_i;
         if (clr_i)     acc_q <= '0;
         else if (en_i) acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/perceptron_multiclass.sv
// Bit-serial multi-class perceptron: accept image, MAC one pixel/cycle in all lanes, arg-max, hold result.
// out_valid rises WIDTH+1 edges after accept; in_ready low until the result is taken via out_ready.
module perceptron_multiclass
   import perceptron_pkg::*;
#(
   parameter int WIDTH   = 25,
   parameter int N_CLASS = 2,
   parameter int W_BITS  = 3,
   parameter int THRESH  = 4,
   localparam int ACC_W  = acc_width(W_BITS, WIDTH),
   localparam int CLS_W  = (N_CLASS > 1) ? $clog2(N_CLASS) : 1,
   localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         in,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     wr_en,
   input  logic [CLS_W-1:0]         wr_class,
   input  logic [IDX_W-1:0]         wr_idx,
   input  logic signed [W_BITS-1:0] wr_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CLS_W-1:0]         out_class,
   output logic signed [ACC_W-1:0]  out_score,
   output logic                     out_hit
);

   state_t                  state_q;
   logic [IDX_W-1:0]        cnt_q;
   logic [WIDTH-1:0]        in_sr_q;
   logic                    out_valid_q;
   logic [CLS_W-1:0]        out_class_q;
   logic signed [ACC_W-1:0] out_score_q;
   logic                    out_hit_q;

   logic                    accept;
   logic                    wr_ok;
   logic signed [ACC_W-1:0] acc [N_CLASS];
   logic [CLS_W-1:0]        win_d;
   logic signed [ACC_W-1:0] score_d;

   assign accept = (state_q == IDLE) && in_valid;
   assign wr_ok  = (state_q == IDLE) && wr_en;

   for (genvar c = 0; c < N_CLASS; c++) begin : g_lane
      perceptron_mac_lane #(
         .WIDTH (WIDTH),
         .W_BITS(W_BITS),
         .ACC_W (ACC_W),
         .IDX_W (IDX_W)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .wr_en_i  (wr_ok && (wr_class == CLS_W'(c))),
         .wr_idx_i (wr_idx),
         .wr_data_i(wr_data),
         .clr_i    (accept),
         .en_i     (state_q == ACCUM),
         .pix_idx_i(cnt_q),
         .pix_i    (in_sr_q[0]),
         .acc_o    (acc[c])
      );
   end

   // Strict greater-than keeps the lowest index on ties.
   always_comb begin
      win_d   = '0;
      score_d = acc[0];
      for (int c = 1; c < N_CLASS; c++) begin
         if (acc[c] > score_d) begin
            win_d   = CLS_W'(c);
            score_d = acc[c];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         in_sr_q     <= '0;
         out_valid_q <= 1'b0;
         out_class_q <= '0;
         out_score_q <= '0;
         out_hit_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  in_sr_q <= in;
                  cnt_q   <= '0;
                  state_q <= ACCUM;
               end
            end
            ACCUM: begin
               in_sr_q <= in_sr_q >> 1;
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == IDX_W'(WIDTH - 1)) state_q <= DECIDE;
            end
            DECIDE: begin
               out_class_q <= win_d;
               out_score_q <= score_d;
               out_hit_q   <= (score_d >= ACC_W'(THRESH));
               out_valid_q <= 1'b1;
               state_q     <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign out_class = out_class_q;
   assign out_score = out_score_q;
   assign out_hit   = out_hit_q;

endmodule

// File: tb/tb_perceptron_multiclass.sv
// Directed bench for perceptron_multiclass: table of weight-set/image vectors plus hand sequences
// for backpressure, dropped mid-frame writes, same-edge write+accept and mid-frame reset.
module tb_perceptron_multiclass;

   logic              clk = 1'b0;
   logic              rst;
   logic [24:0]       in_img;
   logic              in_valid;
   logic              in_ready;
   logic              wr_en;
   logic [0:0]        wr_class;
   logic [4:0]        wr_idx;
   logic signed [2:0] wr_data;
   logic              out_valid;
   logic              out_ready;
   logic [0:0]        out_class;
   logic signed [7:0] out_score;
   logic              out_hit;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   perceptron_multiclass dut (
      .clk      (clk),
      .rst      (rst),
      .in       (in_img),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .wr_en    (wr_en),
      .wr_class (wr_class),
      .wr_idx   (wr_idx),
      .wr_data  (wr_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_class(out_class),
      .out_score(out_score),
      .out_hit  (out_hit)
   );

   typedef struct {
      int          ws;
      logic [24:0] img;
      int          ecls;
      int          escore;
      int          ehit;
      int          eacc1;
   } vec_t;

   localparam logic [24:0] IMG_ONES = 25'h1FFFFFF;
   localparam logic [24:0] IMG_X    = 25'h1151151;
   localparam logic [24:0] IMG_O    = 25'h0404404;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int wval(input int ws, input int c, input int i);
      case (ws)
         1: return (c == 1) ? ((i == 12) ? 3 : ((i == 0 || i == 4 || i == 20 || i == 24) ? 2 : 0)) : 0;
         2: return (c == 0) ? ((i == 2 || i == 10 || i == 14 || i == 22) ? 1 : 0) : -1;
         3: return (c == 0) ? -2 : -1;
         4: return 3;
         5: return -4;
         default: return 0;
      endcase
   endfunction

   // All tasks start and end just after a falling edge.
   task automatic wr(input int c, input int i, input int v);
      wr_en    = 1'b1;
      wr_class = 1'(c);
      wr_idx   = 5'(i);
      wr_data  = 3'(v);
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic load_ws(input int ws);
      for (int c = 0; c < 2; c++)
         for (int i = 0; i < 25; i++) wr(c, i, wval(ws, c, i));
   endtask

   task automatic start_frame(input string nm, input logic [24:0] img);
      chk({nm, " in_ready before accept"}, int'(in_ready), 1);
      in_img   = img;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic finish_frame(input string nm, input int ecls, input int escore, input int ehit);
      chk({nm, " class"}, int'(out_class), ecls);
      chk({nm, " score"}, int'(out_score), escore);
      chk({nm, " hit"}, int'(out_hit), ehit);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({nm, " out_valid after handshake"}, int'(out_valid), 0);
      chk({nm, " in_ready after handshake"}, int'(in_ready), 1);
   endtask

   task automatic run_frame(input string nm, input logic [24:0] img,
                            input int ecls, input int escore, input int ehit);
      int lat;
      start_frame(nm, img);
      wait_valid(lat);
      chk({nm, " latency"}, lat, 26);
      finish_frame(nm, ecls, escore, ehit);
   endtask

   initial begin
      vec_t tbl[15];
      int   cur_ws;
      int   lat;
      int   seen;
      int   stable;

      tbl[0]  = '{0, IMG_ONES, 0,    0, 0,    0};
      tbl[1]  = '{1, IMG_X,    1,   11, 1,   11};
      tbl[2]  = '{1, 25'h0,    0,    0, 0,    0};
      tbl[3]  = '{1, 25'h1000, 1,    3, 0,    3};
      tbl[4]  = '{1, 25'h11,   1,    4, 1,    4};
      tbl[5]  = '{2, IMG_O,    0,    4, 1,   -4};
      tbl[6]  = '{2, IMG_ONES, 0,    4, 1,  -25};
      tbl[7]  = '{2, 25'h0,    0,    0, 0,    0};
      tbl[8]  = '{2, 25'h3,    0,    0, 0,   -2};
      tbl[9]  = '{2, 25'h4,    0,    1, 0,   -1};
      tbl[10] = '{3, IMG_ONES, 1,  -25, 0,  -25};
      tbl[11] = '{3, 25'h0,    0,    0, 0,    0};
      tbl[12] = '{3, 25'h1,    1,   -1, 0,   -1};
      tbl[13] = '{4, IMG_ONES, 0,   75, 1,   75};
      tbl[14] = '{5, IMG_ONES, 0, -100, 0, -100};

      rst = 1'b1; in_img = '0; in_valid = 1'b0; wr_en = 1'b0;
      wr_class = '0; wr_idx = '0; wr_data = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      chk("reset in_ready", int'(in_ready), 1);
      chk("reset out_valid", int'(out_valid), 0);
      chk("reset out_class", int'(out_class), 0);
      chk("reset out_score", int'(out_score), 0);
      chk("reset out_hit", int'(out_hit), 0);

      cur_ws = 0;
      for (int v = 0; v < 15; v++) begin
         if (tbl[v].ws != cur_ws) begin
            load_ws(tbl[v].ws);
            cur_ws = tbl[v].ws;
         end
         start_frame($sformatf("vec%0d", v), tbl[v].img);
         wait_valid(lat);
         chk($sformatf("vec%0d latency", v), lat, 26);
         chk($sformatf("vec%0d acc1", v), int'(dut.acc[1]), tbl[v].eacc1);
         finish_frame($sformatf("vec%0d", v), tbl[v].ecls, tbl[v].escore, tbl[v].ehit);
      end

      // Backpressure: result held for 10 cycles while a competing image is offered.
      load_ws(1);
      start_frame("hold", IMG_X);
      wait_valid(lat);
      chk("hold latency", lat, 26);
      for (int k = 0; k < 10; k++) begin
         in_img   = IMG_O;
         in_valid = 1'b1;
         @(negedge clk);
         stable = (out_valid && !in_ready && out_class == 1'b1 && out_score == 8'sd11 && out_hit) ? 1 : 0;
         chk($sformatf("hold stable cycle %0d", k), stable, 1);
      end
      in_valid = 1'b0;
      finish_frame("hold", 1, 11, 1);
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (out_valid || !in_ready) seen++;
      end
      chk("hold no ghost frame", seen, 0);

      // Write issued mid-ACCUM must be dropped.
      start_frame("accum_wr", IMG_X);
      repeat (3) @(negedge clk);
      wr(1, 12, -4);
      wait_valid(lat);
      chk("accum_wr latency", lat + 4, 26);
      finish_frame("accum_wr", 1, 11, 1);

      // Write and accept on the same edge: frame sees the new weight.
      wr_en = 1'b1; wr_class = 1'b1; wr_idx = 5'd12; wr_data = -3'sd4;
      in_img = IMG_X; in_valid = 1'b1;
      @(negedge clk);
      wr_en = 1'b0; in_valid = 1'b0;
      wait_valid(lat);
      chk("same_edge latency", lat, 26);
      finish_frame("same_edge", 1, 4, 1);

      // Reset at ACCUM cycle 10 aborts the frame and clears the weights.
      load_ws(1);
      start_frame("rst_mid", IMG_X);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid in_ready", int'(in_ready), 1);
      chk("rst_mid out_valid", int'(out_valid), 0);
      chk("rst_mid out_class", int'(out_class), 0);
      chk("rst_mid out_score", int'(out_score), 0);
      chk("rst_mid out_hit", int'(out_hit), 0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("rst_mid no result", seen, 0);
      run_frame("rst_mid weights cleared", IMG_ONES, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
